// File: rtl/con_feeder.sv
// con_feeder: fetches kernel and feature-map words from 1-cycle memory and streams them on con_valid/con_ready.
// Latency: start sampled at edge N -> first read in N+1 -> first con_valid in N+3; 1 word/cycle sustained.
// Backpressure: 2-entry registered FIFO; reads issue only while FIFO+inflight has room. Optional stall counter: CON_FEEDER_STALL_CNT_EN.
module con_feeder #(
  parameter int DATA_WIDTH         = 16,
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int NB_CH_GROUPS       = 11,
  parameter int K_WORDS            = 60,
  parameter int PRELOAD_WORDS      = 16,
  parameter int X_WORDS            = 4,
  parameter int K_BASE             = 0,
  parameter int I_BASE             = 65536
) (
  input  logic                          clk,
  input  logic                          arst_in,
  input  logic                          start,
  output logic                          running,
  output logic                          done,
  output logic                          mem_re,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          con_valid,
  input  logic                          con_ready,
  output logic [DATA_WIDTH-1:0]         con_data,
  output logic [31:0]                   stall_cycles
);

  localparam int AW        = LOG2_OF_MEM_HEIGHT;
  localparam int ROW_WORDS = PRELOAD_WORDS + FEATURE_MAP_WIDTH * X_WORDS;

  localparam logic [AW-1:0] K_LAST   = AW'(K_WORDS - 1);
  localparam logic [AW-1:0] P_LAST   = AW'(PRELOAD_WORDS - 1);
  localparam logic [AW-1:0] R_LAST   = AW'(ROW_WORDS - 1);
  localparam logic [AW-1:0] Y_LAST   = AW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [AW-1:0] G_LAST   = AW'(NB_CH_GROUPS - 1);
  localparam logic [AW-1:0] K_STRIDE = AW'(K_WORDS);
  localparam logic [AW-1:0] R_STRIDE = AW'(ROW_WORDS);
  localparam logic [AW-1:0] K_BASE_A = AW'(K_BASE);
  localparam logic [AW-1:0] I_BASE_A = AW'(I_BASE);

  typedef enum logic [2:0] {
    IDLE,
    KERNEL,
    PRELOAD,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [AW-1:0] r_q, r_d;
  logic [AW-1:0] y_q, y_d;
  logic [AW-1:0] g_q, g_d;

  logic                  inflight_q;
  logic [1:0]            cnt_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  logic pop;
  logic push;
  logic issuing;
  logic room;

  // The head register is the output word, so con_data/con_valid come straight from flops.
  assign con_valid = (cnt_q != 2'd0);
  assign con_data  = head_q;
  assign pop       = con_valid && con_ready;
  assign push      = inflight_q;
  assign running   = (state_q != IDLE);

  // Room counts the word in flight and credits this cycle's pop, so a full FIFO
  // being drained still lets a read issue and the stream has no bubbles.
  assign issuing = (state_q == KERNEL) || (state_q == PRELOAD) || (state_q == STREAM);
  assign room    = (({1'b0, cnt_q} + {2'b00, inflight_q}) - {2'b00, pop}) < 3'd2;
  assign mem_re  = issuing && room;

  // State, counters and read-in-flight flag.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state_q    <= IDLE;
      k_q        <= '0;
      r_q        <= '0;
      y_q        <= '0;
      g_q        <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_q        <= r_d;
      y_q        <= y_d;
      g_q        <= g_d;
      inflight_q <= mem_re;
    end
  end

  // Next-state, address generation and done pulse; counters move only on an issued read.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    r_d      = r_q;
    y_d      = y_q;
    g_d      = g_q;
    done     = 1'b0;
    mem_addr = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = KERNEL;
          k_d     = '0;
          r_d     = '0;
          y_d     = '0;
          g_d     = '0;
        end
      end
      KERNEL: begin
        mem_addr = K_BASE_A + g_q * K_STRIDE + k_q;
        if (mem_re) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = PRELOAD;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      PRELOAD: begin
        mem_addr = I_BASE_A + y_q * R_STRIDE + r_q;
        if (mem_re) begin
          r_d = r_q + 1'b1;
          if (r_q == P_LAST) state_d = STREAM;
        end
      end
      STREAM: begin
        mem_addr = I_BASE_A + y_q * R_STRIDE + r_q;
        if (mem_re) begin
          if (r_q == R_LAST) begin
            r_d = '0;
            if (y_q != Y_LAST) begin
              y_d     = y_q + 1'b1;
              state_d = PRELOAD;
            end else begin
              // Input addressing restarts at the region base for the next group.
              y_d = '0;
              if (g_q != G_LAST) begin
                g_d     = g_q + 1'b1;
                state_d = KERNEL;
              end else begin
                state_d = DRAIN;
              end
            end
          end else begin
            r_d = r_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Last word: nothing in flight and the only FIFO entry leaves this cycle.
        if (!inflight_q && (cnt_q == 2'd1) && pop) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Two-entry FIFO as head/tail registers; a pop with two entries shifts tail into head.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_q <= mem_rdata;
            cnt_q  <= 2'd1;
          end else begin
            tail_q <= mem_rdata;
            cnt_q  <= 2'd2;
          end
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= mem_rdata;
          end else begin
            head_q <= tail_q;
            tail_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CON_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the consumer holds off a valid word.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      stall_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      stall_q <= '0;
    end else if (con_valid && !con_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_con_feeder.sv
// tb_con_feeder: directed bench for con_feeder with small geometry and address-as-data memories.
// Latency: checks first read at start+1, first word at start+3, back-to-back words at full rate.
// Backpressure: exercises toggled and long stalls, data hold, mid-stream reset, ignored restart.
module tb_con_feeder;

  logic clk = 1'b0;
  logic arst_in;
  logic start;
  logic con_ready;
  logic sel;

  logic        run1, done1, re1, valid1;
  logic [19:0] addr1;
  logic [15:0] rdata1, data1;
  logic [31:0] stall1;

  logic        run2, done2, re2, valid2;
  logic [19:0] addr2;
  logic [15:0] rdata2, data2;
  logic [31:0] stall2;

  logic        m_run, m_done, m_re, m_valid;
  logic [19:0] m_addr;
  logic [15:0] m_data;
  logic [31:0] m_stall;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  con_feeder #(
    .DATA_WIDTH(16), .LOG2_OF_MEM_HEIGHT(20), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .NB_CH_GROUPS(1), .K_WORDS(12), .PRELOAD_WORDS(4), .X_WORDS(2), .K_BASE(0), .I_BASE(100)
  ) u1 (
    .clk(clk), .arst_in(arst_in), .start(start), .running(run1), .done(done1),
    .mem_re(re1), .mem_addr(addr1), .mem_rdata(rdata1), .con_valid(valid1),
    .con_ready(con_ready), .con_data(data1), .stall_cycles(stall1)
  );

  con_feeder #(
    .DATA_WIDTH(16), .LOG2_OF_MEM_HEIGHT(20), .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2),
    .NB_CH_GROUPS(2), .K_WORDS(12), .PRELOAD_WORDS(4), .X_WORDS(2), .K_BASE(0), .I_BASE(100)
  ) u2 (
    .clk(clk), .arst_in(arst_in), .start(start), .running(run2), .done(done2),
    .mem_re(re2), .mem_addr(addr2), .mem_rdata(rdata2), .con_valid(valid2),
    .con_ready(con_ready), .con_data(data2), .stall_cycles(stall2)
  );

  // Memories return their address as data, one cycle after the read.
  always @(posedge clk) begin
    if (re1) rdata1 <= addr1[15:0];
    if (re2) rdata2 <= addr2[15:0];
  end

  // Monitored instance select.
  always_comb begin
    m_run   = sel ? run2   : run1;
    m_done  = sel ? done2  : done1;
    m_re    = sel ? re2    : re1;
    m_valid = sel ? valid2 : valid1;
    m_addr  = sel ? addr2  : addr1;
    m_data  = sel ? data2  : data1;
    m_stall = sel ? stall2 : stall1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hand sequence per group: kernel g*12+0..11, then input 100..115.
  function automatic int exp_word(input int i);
    int j, g;
    g = i / 28;
    j = i % 28;
    if (j < 12) return g * 12 + j;
    return 100 + (j - 12);
  endfunction

  // mode 0: ready always high; 1: ready toggles; 2: ready low 20 cycles from first valid.
  task automatic stream_run(input bit use2, input int mode, input int again_at, input int n_exp);
    int idx, stalls, stall_reads, first_cyc, last_cyc, vfirst, cyc;
    bit holding, finished;
    logic [15:0] held;
    idx = 0; stalls = 0; stall_reads = 0; first_cyc = 0; last_cyc = 0; vfirst = 0;
    holding = 0; finished = 0; held = '0;
    sel = use2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    for (cyc = 1; cyc <= 400 && !finished; cyc++) begin
      #1;
      start = (cyc == again_at);
      case (mode)
        0: con_ready = 1'b1;
        1: con_ready = ((cyc % 2) == 1);
        default: con_ready = (vfirst != 0) && (cyc >= vfirst + 20);
      endcase
      @(negedge clk);
      if (cyc == 1) begin
        chk("first_re", 32'(m_re), 32'd1);
        chk("first_addr", 32'(m_addr), 32'd0);
        chk("running", 32'(m_run), 32'd1);
      end
      if (vfirst == 0 && m_valid) vfirst = cyc;
      if (mode == 2 && vfirst != 0 && cyc < vfirst + 20) begin
        if (m_re) stall_reads++;
        if (cyc == vfirst + 19) chk("stall_mem_re", 32'(m_re), 32'd0);
      end
      if (holding) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", 32'(m_data), 32'(held));
        holding = 0;
      end
      if (m_valid && con_ready) begin
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        chk("data", 32'(m_data), 32'(exp_word(idx)));
        chk("done", 32'(m_done), 32'(idx == n_exp - 1));
        idx++;
        if (m_done) finished = 1;
      end else if (m_valid) begin
        stalls++;
        held = m_data;
        holding = 1;
      end
      @(posedge clk);
    end
    chk("finished", 32'(finished), 32'd1);
    chk("word_count", 32'(idx), 32'(n_exp));
    if (mode == 0) begin
      chk("first_cycle", 32'(first_cyc), 32'd3);
      chk("span", 32'(last_cyc - first_cyc), 32'(n_exp - 1));
    end
    if (mode == 2) chk("stall_reads_le2", 32'(stall_reads <= 2), 32'd1);
    #1 start = 1'b0;
    @(negedge clk);
    chk("running_after", 32'(m_run), 32'd0);
    chk("valid_after", 32'(m_valid), 32'd0);
`ifdef CON_FEEDER_STALL_CNT_EN
    chk("stall_cycles", m_stall, 32'(stalls));
`else
    chk("stall_cycles", m_stall, 32'd0);
`endif
  endtask

  task automatic settle();
    int i;
    con_ready = 1'b1;
    start = 1'b0;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!run1 && !run2) break;
    end
    chk("settle", 32'(run1 | run2), 32'd0);
  endtask

  initial begin
    int n;
    arst_in = 1'b0; start = 1'b0; con_ready = 1'b0; sel = 1'b0;
    #1 arst_in = 1'b1;
    #2;
    chk("rst_running", 32'(run1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_mem_re", 32'(re1), 32'd0);
    chk("rst_mem_addr", 32'(addr1), 32'd0);
    chk("rst_valid", 32'(valid1), 32'd0);
    chk("rst_data", 32'(data1), 32'd0);
    chk("rst_stall", stall1, 32'd0);
    repeat (2) @(posedge clk);
    #1 arst_in = 1'b0;

    stream_run(1'b0, 0, 0, 28);
    settle();
    stream_run(1'b0, 1, 0, 28);
    settle();
    stream_run(1'b0, 2, 0, 28);
    settle();
    stream_run(1'b1, 0, 0, 56);
    settle();
    stream_run(1'b0, 0, 20, 28);
    settle();

    // Reset after 10 transfers, then replay from address 0.
    sel = 1'b0;
    con_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      @(negedge clk);
      if (valid1 && con_ready) n++;
    end
    chk("pre_reset_count", 32'(n), 32'd10);
    #2 arst_in = 1'b1;
    #1;
    chk("mid_rst_running", 32'(run1), 32'd0);
    chk("mid_rst_done", 32'(done1), 32'd0);
    chk("mid_rst_mem_re", 32'(re1), 32'd0);
    chk("mid_rst_mem_addr", 32'(addr1), 32'd0);
    chk("mid_rst_valid", 32'(valid1), 32'd0);
    chk("mid_rst_data", 32'(data1), 32'd0);
    chk("mid_rst_stall", stall1, 32'd0);
    @(posedge clk); #1 arst_in = 1'b0;
    settle();
    stream_run(1'b0, 0, 0, 28);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
